// File: rtl/master_fsm_pkg.sv
// Shared definitions for the req/ack byte handshake (initiator and responder).
// State encoding and payload width are common to both sides of the link.
package master_fsm_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_LOW = 3'd2,
    DONE     = 3'd3,
    ERR      = 3'd4
  } state_t;

endpackage

// File: rtl/master_fsm_if.sv
// Bundle between command logic, the initiator FSM and the responder.
// Handshake: 4-phase; req rises, ack rises, req falls, ack falls; data_out is stable while req or ack is high.
interface master_fsm_if;
  import master_fsm_pkg::*;

  logic   start;
  byte_t  base_byte;
  logic   ack;
  logic   req;
  byte_t  data_out;
  logic   busy;
  logic   done;
  logic   err;
  byte_t  sent_cnt;
  state_t state;

  modport master (
    input  start, base_byte, ack,
    output req, data_out, busy, done, err, sent_cnt, state
  );

  modport slave (
    output start, base_byte, ack,
    input  req, data_out, busy, done, err, sent_cnt, state
  );

endinterface

// File: rtl/master_fsm_timeout_ctr.sv
// Cycle counter for handshake timeouts; expired is high on the last allowed cycle.
// Shared with the responder, so it knows nothing about initiator states.
module hs_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/master_fsm.sv
// Initiator of the 4-phase req/ack byte handshake: sends BURST_LEN bytes
// base, base+1, ... and aborts with an err pulse when ack never arrives.
module master_fsm
    import master_fsm_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic         clk,
    input  logic         rst,
    master_fsm_if.master bus
);

    localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    byte_t            base_q, base_n;
    byte_t            data_q, data_n;
    byte_t            cnt_q, cnt_n;
    logic             err_q;
    logic             tmo_clr, tmo_en, tmo_exp;

    hs_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clr),
        .enable  (tmo_en),
        .expired (tmo_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            base_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            base_q <= base_n;
            data_q <= data_n;
            cnt_q  <= cnt_n;
            // err marks only the entry cycle into ERR
            err_q  <= (state_n == ERR) && (state != ERR);
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        base_n  = base_q;
        data_n  = data_q;
        cnt_n   = cnt_q;
        tmo_clr = 1'b0;
        tmo_en  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    base_n  = bus.base_byte;
                    idx_n   = '0;
                    cnt_n   = '0;
                    data_n  = bus.base_byte;
                    tmo_clr = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (bus.ack) begin
                    state_n = WAIT_LOW;
                end else if (tmo_exp) begin
                    state_n = ERR;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!bus.ack) begin
                    cnt_n = cnt_q + 8'd1;
                    if (idx == LAST_IDX) begin
                        state_n = DONE;
                    end else begin
                        idx_n   = idx + 1'b1;
                        data_n  = base_q + byte_t'(idx) + 8'd1;
                        tmo_clr = 1'b1;
                        state_n = REQ;
                    end
                end
            end
            DONE: state_n = IDLE;
            ERR: begin
                if (!bus.ack) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.req      = (state == REQ);
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.err      = err_q;
    assign bus.data_out = data_q;
    assign bus.sent_cnt = cnt_q;
    assign bus.state    = state;

endmodule

// File: tb/tb_master_fsm.sv
// Bench for master_fsm: a behavioural responder drives ack, and each burst is
// checked against byte/timing expectations derived from the handshake rules.
module tb_master_fsm;
  import master_fsm_pkg::*;

  localparam int BL  = 4;
  localparam int TMO = 16;

  logic clk;
  logic rst;
  master_fsm_if bus();

  master_fsm #(.BURST_LEN(BL), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // responder: holds ack for hold_len cycles after seeing req, logs captured bytes
  logic   resp_en;
  int     hold_len;
  int     hold;
  logic [7:0] got_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ack <= 1'b0;
      hold    <= 0;
    end else if (bus.ack) begin
      if (hold <= 1) begin
        bus.ack <= 1'b0;
        hold    <= 0;
      end else begin
        hold <= hold - 1;
      end
    end else if (resp_en && bus.req) begin
      bus.ack <= 1'b1;
      hold    <= hold_len;
      got_q.push_back(bus.data_out);
    end
  end

  // driver tasks
  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_checks++;
    if ({bus.req, bus.busy, bus.done, bus.err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: req/busy/done/err=%b expected 0000", {bus.req, bus.busy, bus.done, bus.err});
    end
    n_checks++;
    if (bus.data_out !== 8'h00 || bus.sent_cnt !== 8'h00) begin
      n_fail++; $display("FAIL reset_data: data_out=%h sent_cnt=%0d expected 00/0", bus.data_out, bus.sent_cnt);
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_burst(input logic [7:0] base, input int h, input bit again);
    logic [7:0] exp_q[$];
    int rises = 0, done_cnt = 0, done_cyc = -1, err_cnt = 0;
    int bad_stable = 0, bad_timing = 0, bad_bytes = 0, n_cyc;
    logic prev_req = 1'b0;
    for (int k = 0; k < BL; k++) exp_q.push_back(base + 8'(k));
    got_q.delete();
    hold_len = h;
    resp_en  = 1'b1;
    n_cyc    = BL * (h + 2) + 4;
    @(negedge clk); bus.start = 1'b1; bus.base_byte = base;
    @(negedge clk); bus.start = 1'b0; bus.base_byte = 8'($urandom_range(0, 255));
    for (int cyc = 1; cyc <= n_cyc; cyc++) begin
      if (bus.req && !prev_req) begin
        if (cyc != 1 + rises * (h + 2) || bus.ack) bad_timing++;
        rises++;
      end
      if (rises > 0 && bus.busy && bus.data_out !== base + 8'(rises - 1)) bad_stable++;
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (bus.err) err_cnt++;
      prev_req = bus.req;
      bus.start = again && (cyc == 3 || cyc == 8);
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (got_q.size() != exp_q.size()) bad_bytes++;
    else for (int k = 0; k < exp_q.size(); k++) if (got_q[k] !== exp_q[k]) bad_bytes++;

    n_checks++;
    if (rises != BL) begin n_fail++; $display("FAIL req_count base=%h: %0d expected %0d", base, rises, BL); end
    n_checks++;
    if (bad_timing != 0) begin n_fail++; $display("FAIL req_timing base=%h: %0d late/early req edges expected 0", base, bad_timing); end
    n_checks++;
    if (bad_stable != 0) begin n_fail++; $display("FAIL data_stable base=%h: %0d bad cycles expected 0", base, bad_stable); end
    n_checks++;
    if (bad_bytes != 0) begin n_fail++; $display("FAIL byte_seq base=%h: %0d bad bytes (got %0d bytes) expected 0", base, bad_bytes, got_q.size()); end
    n_checks++;
    if (done_cnt != 1 || done_cyc != 1 + BL * (h + 2)) begin
      n_fail++; $display("FAIL done_pulse base=%h: count=%0d cycle=%0d expected 1 at %0d", base, done_cnt, done_cyc, 1 + BL * (h + 2));
    end
    n_checks++;
    if (err_cnt != 0) begin n_fail++; $display("FAIL err_quiet base=%h: %0d err cycles expected 0", base, err_cnt); end
    n_checks++;
    if (bus.sent_cnt !== 8'(BL) || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL end_state base=%h: sent_cnt=%0d busy=%b expected %0d/0", base, bus.sent_cnt, bus.busy, BL);
    end
  endtask

  task automatic test_timeout();
    int bad_req = 0, bad_err = 0, bad_busy = 0;
    resp_en = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.base_byte = 8'($urandom_range(0, 255));
    @(negedge clk); bus.start = 1'b0;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      if (bus.req !== (cyc >= 1 && cyc <= TMO)) bad_req++;
      if (bus.err !== (cyc == TMO + 1)) bad_err++;
      if (bus.busy !== (cyc <= TMO + 1)) bad_busy++;
      @(negedge clk);
    end
    n_checks++;
    if (bad_req != 0) begin n_fail++; $display("FAIL tmo_req: %0d bad cycles expected 0", bad_req); end
    n_checks++;
    if (bad_err != 0) begin n_fail++; $display("FAIL tmo_err: %0d bad cycles expected 0", bad_err); end
    n_checks++;
    if (bad_busy != 0) begin n_fail++; $display("FAIL tmo_busy: %0d bad cycles expected 0", bad_busy); end
    n_checks++;
    if (bus.sent_cnt !== 8'h00) begin n_fail++; $display("FAIL tmo_sent_cnt: %0d expected 0", bus.sent_cnt); end
  endtask

  task automatic test_async_reset();
    int rises = 0, budget = 0;
    logic prev_req = 1'b0;
    hold_len = 3;
    resp_en  = 1'b1;
    @(negedge clk); bus.start = 1'b1; bus.base_byte = 8'h5C;
    @(negedge clk); bus.start = 1'b0;
    while (rises < 2 && budget < 40) begin
      if (bus.req && !prev_req) rises++;
      prev_req = bus.req;
      if (rises < 2) @(negedge clk);
      budget++;
    end
    n_checks++;
    if (rises < 2) begin n_fail++; $display("FAIL rst_wait: saw %0d req edges expected 2", rises); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.req, bus.busy, bus.done, bus.err} !== 4'b0000 || bus.sent_cnt !== 8'h00) begin
      n_fail++; $display("FAIL rst_async: req/busy/done/err=%b sent_cnt=%0d expected 0000/0", {bus.req, bus.busy, bus.done, bus.err}, bus.sent_cnt);
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.req !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_quiet: req=%b busy=%b expected 0/0", bus.req, bus.busy);
    end
    run_burst(8'h33, 3, 1'b0);
  endtask

  // main sequence and report
  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.base_byte = 8'h00;
    resp_en       = 1'b1;
    hold_len      = 3;
    test_reset();
    run_burst(8'hA0, 3, 1'b0);
    run_burst(8'hFE, 3, 1'b0);
    for (int i = 0; i < 3; i++) run_burst(8'($urandom_range(0, 255)), 3, 1'b0);
    test_timeout();
    repeat (3) @(negedge clk);
    test_async_reset();
    run_burst(8'h7F, 3, 1'b1);
    run_burst(8'($urandom_range(0, 255)), 7, 1'b0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
